// File: rtl/joy_serial_pkg.sv
// ============================================================================
// Module      : joy_serial_pkg
// Description : Shared state encoding and default sizing for the serial
//               joystick decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package joy_serial_pkg;

   typedef enum logic [1:0] {
      LOAD     = 2'd0,
      SHIFT_LO = 2'd1,
      SHIFT_HI = 2'd2
   } joy_state_t;

   localparam int c_NUM_JOY_DEFAULT      = 2;
   localparam int c_BITS_PER_JOY_DEFAULT = 8;
   localparam int c_CLK_DIV_DEFAULT      = 8;

   // Index width able to hold total-1; a one-bit chain still needs one bit.
   function automatic int idx_width(input int total);
      return (total > 1) ? $clog2(total) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/joy_tick_gen.sv
// ============================================================================
// Module      : joy_tick_gen
// Description : Free-running divider; asserts tick on the last count of each
//               CLK_DIV-cycle period.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module joy_tick_gen
   import joy_serial_pkg::*;
#(
   parameter int CLK_DIV = c_CLK_DIV_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   output logic o_tick
);

   localparam int                 c_CNT_W = $clog2(CLK_DIV);
   localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(CLK_DIV - 1);

   logic [c_CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (r_cnt == c_LAST) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + c_CNT_W'(1);
      end
   end

   assign o_tick = (r_cnt == c_LAST);

endmodule

`default_nettype wire

// File: rtl/joy_serial_decoder.sv
// ============================================================================
// Module      : joy_serial_decoder
// Description : Drives a parallel-in/serial-out joystick chain and assembles
//               the shifted bits into an active-low button vector.
//               Optional macro JOY_DEBOUNCE_EN: only publish a capture that
//               matches the previous frame's capture.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module joy_serial_decoder
   import joy_serial_pkg::*;
#(
   parameter int NUM_JOY      = c_NUM_JOY_DEFAULT,
   parameter int BITS_PER_JOY = c_BITS_PER_JOY_DEFAULT,
   parameter int CLK_DIV      = c_CLK_DIV_DEFAULT
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            joy_data,
   output logic                            joy_clk,
   output logic                            joy_load_n,
   output logic [NUM_JOY*BITS_PER_JOY-1:0] joy_out,
   output logic                            frame_valid
);

   localparam int                 c_TOTAL    = NUM_JOY * BITS_PER_JOY;
   localparam int                 c_IDX_W    = idx_width(c_TOTAL);
   localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_TOTAL - 1);

   joy_state_t         r_state;
   logic [c_IDX_W-1:0] r_idx;
   logic [c_TOTAL-1:0] r_capture;
   logic               w_tick;
   logic               w_frame_end;

   joy_tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_tick_gen (
      .clk    (clk),
      .reset  (reset),
      .o_tick (w_tick)
   );

   assign w_frame_end = w_tick && (r_state == SHIFT_HI) && (r_idx == c_LAST_IDX);

   // Outputs are registered alongside the state so they only move on ticks.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= LOAD;
         r_idx       <= '0;
         r_capture   <= '1;
         joy_clk     <= 1'b0;
         joy_load_n  <= 1'b0;
         frame_valid <= 1'b0;
      end else begin
         frame_valid <= 1'b0;
         if (w_tick) begin
            case (r_state)
               LOAD: begin
                  r_state    <= SHIFT_LO;
                  r_idx      <= '0;
                  joy_load_n <= 1'b1;
                  joy_clk    <= 1'b0;
               end
               SHIFT_LO: begin
                  // First bit off the chain belongs in the top position.
                  r_capture[c_LAST_IDX - r_idx] <= joy_data;
                  r_state                       <= SHIFT_HI;
                  joy_clk                       <= 1'b1;
               end
               SHIFT_HI: begin
                  joy_clk <= 1'b0;
                  if (r_idx == c_LAST_IDX) begin
                     r_state     <= LOAD;
                     joy_load_n  <= 1'b0;
                     frame_valid <= 1'b1;
                  end else begin
                     r_idx   <= r_idx + c_IDX_W'(1);
                     r_state <= SHIFT_LO;
                  end
               end
               default: begin
                  r_state    <= LOAD;
                  r_idx      <= '0;
                  joy_load_n <= 1'b0;
                  joy_clk    <= 1'b0;
               end
            endcase
         end
      end
   end

`ifdef JOY_DEBOUNCE_EN
   logic [c_TOTAL-1:0] r_prev_frame;

   // A capture is published only once two consecutive frames agree.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         joy_out      <= '1;
         r_prev_frame <= '1;
      end else if (w_frame_end) begin
         r_prev_frame <= r_capture;
         if (r_capture == r_prev_frame) begin
            joy_out <= r_capture;
         end
      end
   end
`else
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         joy_out <= '1;
      end else if (w_frame_end) begin
         joy_out <= r_capture;
      end
   end
`endif

endmodule

`default_nettype wire
